// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates gated synaptic values over a timestep,
// then leaks, thresholds and emits one registered spike decision per timestep.
module lif_neuron #(
    parameter int W          = 16,
    parameter int VW         = 24,
    parameter int THRESH     = 1000,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC     = 2,
    parameter int V_RESET    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [W-1:0]  v_in,
    output logic                 in_ready,
    input  logic                 step_end,
    output logic                 spike_valid,
    output logic                 spike_out,
    output logic signed [VW-1:0] v_mem
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [VW-1:0] THRESH_V  = VW'(THRESH);
    localparam logic signed [VW-1:0] V_RESET_V = VW'(V_RESET);
    localparam logic [RW-1:0]        REFRAC_V  = RW'(REFRAC);

    typedef enum logic {
        INTEG = 1'b0,
        EVAL  = 1'b1
    } state_t;

    // One guard bit is enough to detect overflow of acc + sext(v_in).
    function automatic logic signed [VW-1:0] sat_add(
        input logic signed [VW-1:0] a,
        input logic signed [W-1:0]  b
    );
        logic signed [VW:0] sum;
        sum = $signed({a[VW-1], a}) + $signed({{(VW + 1 - W){b[W-1]}}, b});
        if (sum[VW] != sum[VW-1]) begin
            if (sum[VW]) return {1'b1, {(VW - 1){1'b0}}};
            else         return {1'b0, {(VW - 1){1'b1}}};
        end
        return sum[VW-1:0];
    endfunction

    // Magnitude never grows, so no saturation is needed here.
    function automatic logic signed [VW-1:0] leak(input logic signed [VW-1:0] a);
        if (LEAK_SHIFT == 0) return a;
        return a - (a >>> LEAK_SHIFT);
    endfunction

    state_t                 state;
    state_t                 state_nx;
    logic signed [VW-1:0]   acc;
    logic signed [VW-1:0]   acc_nx;
    logic signed [VW-1:0]   lk;
    logic [RW-1:0]          ref_cnt;
    logic [RW-1:0]          ref_nx;
    logic                   fire;

    assign in_ready = (state == INTEG);
    assign v_mem    = acc;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        ref_nx   = ref_cnt;
        fire     = 1'b0;
        lk       = leak(acc);
        case (state)
            INTEG: begin
                if (in_valid && (ref_cnt == '0)) acc_nx = sat_add(acc, v_in);
                if (step_end) state_nx = EVAL;
            end
            EVAL: begin
                state_nx = INTEG;
                if (ref_cnt != '0) begin
                    ref_nx = ref_cnt - RW'(1);
                end else if (lk >= THRESH_V) begin
                    fire   = 1'b1;
                    acc_nx = V_RESET_V;
                    ref_nx = REFRAC_V;
                end else begin
                    acc_nx = lk;
                end
            end
            default: state_nx = INTEG;
        endcase
    end

    // Decision is registered one cycle after EVAL so the pulse is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INTEG;
            acc         <= V_RESET_V;
            ref_cnt     <= '0;
            spike_valid <= 1'b0;
            spike_out   <= 1'b0;
        end else begin
            state       <= state_nx;
            acc         <= acc_nx;
            ref_cnt     <= ref_nx;
            spike_valid <= (state == EVAL);
            spike_out   <= fire;
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: a table of timesteps with hand-computed results,
// plus hand-written saturation, handshake and mid-EVAL reset sequences.
module tb_lif_neuron;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] v_in;
    logic               in_ready;
    logic               step_end;
    logic               spike_valid;
    logic               spike_out;
    logic signed [23:0] v_mem;

    int n_tests = 0;
    int n_fail  = 0;

    lif_neuron dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .v_in        (v_in),
        .in_ready    (in_ready),
        .step_end    (step_end),
        .spike_valid (spike_valid),
        .spike_out   (spike_out),
        .v_mem       (v_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int val;
        bit exp_spike;
        int exp_vmem;
    } row_t;

    row_t tbl[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step_end = 1'b0;
        v_in     = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Feeds n inputs with step_end on the last, then checks the EVAL cycle and the decision.
    task automatic feed_step(input string name, input int n, input int val,
                             input bit exp_spike, input int exp_vmem);
        in_valid = 1'b1;
        v_in     = 16'(val);
        for (int i = 0; i < n; i++) begin
            step_end = (i == n - 1);
            tick();
            if (i == 0) chk({name, ".prev_pulse_gone"}, int'(spike_valid), 0);
        end
        in_valid = 1'b0;
        step_end = 1'b0;
        chk({name, ".eval_ready"}, int'(in_ready), 0);
        tick();
        chk({name, ".spike_valid"}, int'(spike_valid), 1);
        chk({name, ".spike_out"}, int'(spike_out), int'(exp_spike));
        chk({name, ".v_mem"}, int'(v_mem), exp_vmem);
        chk({name, ".ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        tbl[0]  = '{4,   300, 1'b1, 0};
        tbl[1]  = '{4,  2000, 1'b0, 0};
        tbl[2]  = '{4,  2000, 1'b0, 0};
        tbl[3]  = '{1,  2000, 1'b1, 0};
        tbl[4]  = '{1,     0, 1'b0, 0};
        tbl[5]  = '{1,     0, 1'b0, 0};
        tbl[6]  = '{3,   300, 1'b0, 844};
        tbl[7]  = '{1,     0, 1'b0, 792};
        tbl[8]  = '{1,   400, 1'b1, 0};
        tbl[9]  = '{1,     0, 1'b0, 0};
        tbl[10] = '{1,     0, 1'b0, 0};
        tbl[11] = '{1,  1066, 1'b1, 0};
        tbl[12] = '{1,     0, 1'b0, 0};
        tbl[13] = '{1,     0, 1'b0, 0};
        tbl[14] = '{1,  1065, 1'b0, 999};
        tbl[15] = '{1, -2000, 1'b0, -938};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        step_end = 1'b0;
        v_in     = '0;
        #3;
        chk("rst.v_mem", int'(v_mem), 0);
        chk("rst.spike_valid", int'(spike_valid), 0);
        chk("rst.spike_out", int'(spike_out), 0);
        chk("rst.in_ready", int'(in_ready), 1);
        do_reset();

        for (int r = 0; r < 16; r++)
            feed_step($sformatf("row%0d", r), tbl[r].n, tbl[r].val,
                      tbl[r].exp_spike, tbl[r].exp_vmem);

        // Saturation at both rails, starting from v_mem = -938.
        in_valid = 1'b1;
        v_in     = 16'sd32767;
        tick();
        chk("sat.first_add", int'(v_mem), 31829);
        repeat (299) tick();
        chk("sat.pos_rail", int'(v_mem), 8388607);
        tick();
        chk("sat.pos_hold", int'(v_mem), 8388607);
        v_in = -16'sd32768;
        repeat (600) tick();
        chk("sat.neg_rail", int'(v_mem), -8388608);
        feed_step("sat.leak_neg", 1, 0, 1'b0, -7864320);

        // Input held valid across step_end and EVAL.
        do_reset();
        in_valid = 1'b1;
        v_in     = 16'sd500;
        step_end = 1'b0;
        tick();
        chk("hs.first", int'(v_mem), 500);
        step_end = 1'b1;
        tick();
        step_end = 1'b0;
        chk("hs.step_end_counted", int'(v_mem), 1000);
        chk("hs.eval_ready", int'(in_ready), 0);
        tick();
        chk("hs.spike_valid", int'(spike_valid), 1);
        chk("hs.spike_out", int'(spike_out), 0);
        chk("hs.eval_dropped", int'(v_mem), 938);
        chk("hs.ready_back", int'(in_ready), 1);
        tick();
        chk("hs.next_step", int'(v_mem), 1438);
        chk("hs.pulse_one_cycle", int'(spike_valid), 0);
        in_valid = 1'b0;

        // Reset asserted while the neuron is in EVAL with acc = 1200.
        do_reset();
        in_valid = 1'b1;
        v_in     = 16'sd300;
        for (int i = 0; i < 4; i++) begin
            step_end = (i == 3);
            tick();
        end
        in_valid = 1'b0;
        step_end = 1'b0;
        chk("rst_eval.acc", int'(v_mem), 1200);
        chk("rst_eval.in_eval", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_eval.v_mem", int'(v_mem), 0);
        chk("rst_eval.spike_valid", int'(spike_valid), 0);
        chk("rst_eval.in_ready", int'(in_ready), 1);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_eval.no_pulse%0d", i), int'(spike_valid), 0);
        end
        chk("rst_eval.v_mem_after", int'(v_mem), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
